// File: rtl/tinyqv_slice_pkg.sv
// Shared types and elaboration helpers for the TinyQV slice sequencer.
package tinyqv_slice_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of slices that make up one word.
  function automatic int nslice(input int xlen, input int slice_w);
    return xlen / slice_w;
  endfunction

  // Width of a slice index; a single-slice word still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tinyqv_slice_seq.sv
// Slice sequencer for the nibble-serial TinyQV datapath: latches N_IN operands,
// presents them LSB-first one slice per cycle and reassembles the result word.
module tinyqv_slice_seq
  import tinyqv_slice_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 4,
  parameter int N_IN    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  stall,
  input  logic [N_IN*XLEN-1:0]                  op_in,
  input  logic [SLICE_W-1:0]                    res_slice,
  output logic [N_IN*SLICE_W-1:0]               in_slice,
  output logic [idx_w(nslice(XLEN, SLICE_W))-1:0] slice_idx,
  output logic                                  busy,
  output logic                                  first,
  output logic                                  last,
  output logic                                  accept,
  output logic                                  done,
  output logic [XLEN-1:0]                       res_out,
  output logic [XLEN-1:0]                       res_live
);

  localparam int NSLICE = nslice(XLEN, SLICE_W);
  localparam int IW     = idx_w(NSLICE);

  if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 || SLICE_W == 8 ||
        SLICE_W == 16 || SLICE_W == 32) || (XLEN % SLICE_W) != 0) begin : g_bad_cfg
    $error("tinyqv_slice_seq: SLICE_W must be a power of two up to 32 dividing XLEN");
  end

  state_t                 state;
  state_t                 state_nxt;
  logic [N_IN*XLEN-1:0]   op_reg;

  // Status strobes and the start handshake, all derived from current state
  always_comb begin
    busy   = (state == RUN);
    first  = busy && (slice_idx == '0);
    last   = busy && (slice_idx == IW'(NSLICE - 1));
    accept = start && !rst && ((state == IDLE) || (last && !stall));
  end

  // Next state: an unstalled last cycle either retires or chains into a new op
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last && !stall) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, slice index, completed-word register and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      slice_idx <= '0;
      op_reg    <= '0;
      res_out   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && !stall) begin
        if (last) begin
          res_out   <= res_live;
          done      <= 1'b1;
          slice_idx <= '0;
        end else begin
          slice_idx <= slice_idx + IW'(1);
        end
      end
      // A chained start on the last cycle also lands here and restarts at 0.
      if (accept) begin
        op_reg    <= op_in;
        slice_idx <= '0;
      end
    end
  end

  // Per-channel slice mux; outputs are quiet while idle
  always_comb begin
    in_slice = '0;
    if (busy) begin
      for (int c = 0; c < N_IN; c++) begin
        for (int s = 0; s < NSLICE; s++) begin
          if (slice_idx == IW'(s))
            in_slice[c*SLICE_W +: SLICE_W] = op_reg[c*XLEN + s*SLICE_W +: SLICE_W];
        end
      end
    end
  end

  if (NSLICE == 1) begin : g_one
    assign res_live = res_slice;
  end else begin : g_multi
    // Only the non-final slices need storage; the top slice comes live from the core.
    logic [XLEN-SLICE_W-1:0] res_reg;

    // Capture each non-final result slice as the core produces it
    always_ff @(posedge clk) begin
      if (rst) begin
        res_reg <= '0;
      end else if (busy && !stall) begin
        for (int s = 0; s < NSLICE - 1; s++) begin
          if (slice_idx == IW'(s))
            res_reg[s*SLICE_W +: SLICE_W] <= res_slice;
        end
      end
    end

    assign res_live = {res_slice, res_reg};
  end

endmodule

// File: tb/tb_tinyqv_slice_seq.sv
// Directed bench for tinyqv_slice_seq: nibble, bit-serial and full-width instances.
`define CHK(tag, o, e) check(tag, 64'(o), 64'(e))

module tb_tinyqv_slice_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance A: defaults (XLEN 32, SLICE_W 4, N_IN 4)
  logic         start_a = 1'b0, stall_a = 1'b0;
  logic [127:0] op_a = '0;
  logic [3:0]   res_slice_a;
  logic [15:0]  in_slice_a;
  logic [2:0]   idx_a;
  logic         busy_a, first_a, last_a, accept_a, done_a;
  logic [31:0]  res_out_a, res_live_a;

  // Instance B: bit-serial, result looped back from channel 0
  logic         start_b = 1'b0, stall_b = 1'b0;
  logic [63:0]  op_b = '0;
  logic [0:0]   res_slice_b;
  logic [1:0]   in_slice_b;
  logic [4:0]   idx_b;
  logic         busy_b, first_b, last_b, accept_b, done_b;
  logic [31:0]  res_out_b, res_live_b;

  // Instance C: full-width slice, result looped back from channel 0
  logic         start_c = 1'b0, stall_c = 1'b0;
  logic [63:0]  op_c = '0;
  logic [31:0]  res_slice_c;
  logic [63:0]  in_slice_c;
  logic [0:0]   idx_c;
  logic         busy_c, first_c, last_c, accept_c, done_c;
  logic [31:0]  res_out_c, res_live_c;

  assign res_slice_a = {1'b0, idx_a};
  assign res_slice_b = in_slice_b[0];
  assign res_slice_c = in_slice_c[31:0];

  tinyqv_slice_seq #(.XLEN(32), .SLICE_W(4), .N_IN(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stall(stall_a), .op_in(op_a),
    .res_slice(res_slice_a), .in_slice(in_slice_a), .slice_idx(idx_a),
    .busy(busy_a), .first(first_a), .last(last_a), .accept(accept_a),
    .done(done_a), .res_out(res_out_a), .res_live(res_live_a));

  tinyqv_slice_seq #(.XLEN(32), .SLICE_W(1), .N_IN(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stall(stall_b), .op_in(op_b),
    .res_slice(res_slice_b), .in_slice(in_slice_b), .slice_idx(idx_b),
    .busy(busy_b), .first(first_b), .last(last_b), .accept(accept_b),
    .done(done_b), .res_out(res_out_b), .res_live(res_live_b));

  tinyqv_slice_seq #(.XLEN(32), .SLICE_W(32), .N_IN(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .stall(stall_c), .op_in(op_c),
    .res_slice(res_slice_c), .in_slice(in_slice_c), .slice_idx(idx_c),
    .busy(busy_c), .first(first_c), .last(last_c), .accept(accept_c),
    .done(done_c), .res_out(res_out_c), .res_live(res_live_c));

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] exp_c[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [31:0] w, input int k);
    return w[k*4 +: 4];
  endfunction

  // Advance one clock, sample just after the edge and retire any finished result.
  task automatic step();
    @(posedge clk);
    #1;
    if (done_a) begin
      if (exp_a.size() == 0) `CHK("sb_a_extra_done", exp_a.size(), 1);
      else                   `CHK("sb_a_res", res_out_a, exp_a.pop_front());
    end
    if (done_b) begin
      if (exp_b.size() == 0) `CHK("sb_b_extra_done", exp_b.size(), 1);
      else                   `CHK("sb_b_res", res_out_b, exp_b.pop_front());
    end
    if (done_c) begin
      if (exp_c.size() == 0) `CHK("sb_c_extra_done", exp_c.size(), 1);
      else                   `CHK("sb_c_res", res_out_c, exp_c.pop_front());
    end
  endtask

  initial begin
    // Reset state, with start held to show it is not accepted during reset
    rst = 1'b1;
    start_a = 1'b1;
    step();
    step();
    #1;
    `CHK("rst_accept", accept_a, 0);
    `CHK("rst_busy", busy_a, 0);
    `CHK("rst_idx", idx_a, 0);
    `CHK("rst_first_last", {first_a, last_a}, 0);
    `CHK("rst_done", done_a, 0);
    `CHK("rst_res_out", res_out_a, 0);
    `CHK("rst_in_slice", in_slice_a, 0);
    rst = 1'b0;

    // Plain operation: ch0 0x12345678, result slices equal the index
    op_a = {32'h0, 32'h0, 32'h1111_1111, 32'h1234_5678};
    #1;
    `CHK("t1_accept", accept_a, 1);
    exp_a.push_back(32'h7654_3210);
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      `CHK("t1_busy", busy_a, 1);
      `CHK("t1_idx", idx_a, k - 1);
      `CHK("t1_ch0", in_slice_a[3:0], nib(32'h1234_5678, k - 1));
      `CHK("t1_first", first_a, (k == 1));
      `CHK("t1_last", last_a, (k == 8));
      `CHK("t1_done_low", done_a, 0);
      ntests++;
      if (in_slice_a[3:0] !== nib(32'h1234_5678, k - 1)) begin
        nfail++;
        $error("FAIL t1_ch0_direct: observed %0h at slice %0d", in_slice_a[3:0], k - 1);
      end
      if (k == 8) `CHK("t1_res_live", res_live_a, 32'h7654_3210);
      step();
    end
    `CHK("t1_done", done_a, 1);
    `CHK("t1_res_out", res_out_a, 32'h7654_3210);
    `CHK("t1_busy_low", busy_a, 0);
    `CHK("t1_in_idle", in_slice_a, 0);

    // Stall for two cycles while slice 3 is presented
    start_a = 1'b1;
    #1;
    `CHK("t2_accept", accept_a, 1);
    exp_a.push_back(32'h7654_3210);
    step();
    start_a = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      int ei;
      ei = (cyc <= 4) ? cyc - 1 : ((cyc <= 6) ? 3 : cyc - 3);
      `CHK("t2_idx", idx_a, ei);
      `CHK("t2_ch0", in_slice_a[3:0], nib(32'h1234_5678, ei));
      `CHK("t2_first", first_a, (cyc == 1));
      `CHK("t2_last", last_a, (cyc == 10));
      `CHK("t2_done_low", done_a, 0);
      ntests++;
      if (int'(idx_a) != ei) begin
        nfail++;
        $error("FAIL t2_idx_direct: observed %0d expected %0d", idx_a, ei);
      end
      stall_a = (cyc == 4 || cyc == 5);
      step();
    end
    stall_a = 1'b0;
    `CHK("t2_done", done_a, 1);
    `CHK("t2_res_out", res_out_a, 32'h7654_3210);

    // Start mid-run is ignored; start on last chains with no bubble
    op_a = {32'h0, 32'h0, 32'h1111_1111, 32'h1234_5678};
    start_a = 1'b1;
    exp_a.push_back(32'h7654_3210);
    step();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      `CHK("t3_idx", idx_a, cyc - 1);
      `CHK("t3_ch0", in_slice_a[3:0], nib(32'h1234_5678, cyc - 1));
      if (cyc == 3) begin
        start_a = 1'b1;
        op_a = '1;
        #1;
        `CHK("t3_midrun_accept", accept_a, 0);
      end else if (cyc == 8) begin
        start_a = 1'b1;
        op_a = {32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0};
        #1;
        `CHK("t3_chain_accept", accept_a, 1);
        exp_a.push_back(32'h7654_3210);
      end else begin
        start_a = 1'b0;
      end
      step();
    end
    start_a = 1'b0;
    `CHK("t3_b2b_done", done_a, 1);
    `CHK("t3_b2b_first", first_a, 1);
    `CHK("t3_b2b_idx", idx_a, 0);
    `CHK("t3_b2b_ch1", in_slice_a[7:4], 4'h5);
    step();
    for (int k = 2; k <= 8; k++) begin
      `CHK("t3_ch1_idx", idx_a, k - 1);
      `CHK("t3_ch1", in_slice_a[7:4], nib(32'hA5A5_A5A5, k - 1));
      step();
    end
    `CHK("t3_done2", done_a, 1);

    // Reset in the middle of an operation
    op_a = {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
    start_a = 1'b1;
    exp_a.push_back(32'h7654_3210);
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    `CHK("t4_idx5", idx_a, 5);
    `CHK("t4_ch0", in_slice_a[3:0], nib(32'hCAFE_F00D, 5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_a.pop_back());
    `CHK("t4_busy", busy_a, 0);
    `CHK("t4_idx", idx_a, 0);
    `CHK("t4_res_out", res_out_a, 0);
    `CHK("t4_in_slice", in_slice_a, 0);
    `CHK("t4_first_last", {first_a, last_a}, 0);
    `CHK("t4_done", done_a, 0);
    step();
    `CHK("t4_no_done", done_a, 0);
    op_a = {32'h0, 32'h0, 32'h0, 32'h0F1E_2D3C};
    start_a = 1'b1;
    #1;
    `CHK("t4_restart_accept", accept_a, 1);
    exp_a.push_back(32'h7654_3210);
    step();
    start_a = 1'b0;
    `CHK("t4_restart_first", first_a, 1);
    `CHK("t4_restart_ch0", in_slice_a[3:0], 4'hC);
    for (int k = 1; k <= 7; k++) step();
    `CHK("t4_restart_last", last_a, 1);
    step();
    `CHK("t4_restart_done", done_a, 1);

    // Bit-serial instance: 32 RUN cycles
    op_b = {32'h0, 32'hDEAD_BEEF};
    start_b = 1'b1;
    #1;
    `CHK("t5_accept", accept_b, 1);
    exp_b.push_back(32'hDEAD_BEEF);
    step();
    start_b = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      logic [31:0] w;
      w = 32'hDEAD_BEEF;
      `CHK("t5_idx", idx_b, k - 1);
      `CHK("t5_bit", in_slice_b[0], w[k-1]);
      `CHK("t5_last", last_b, (k == 32));
      `CHK("t5_done_low", done_b, 0);
      ntests++;
      if (in_slice_b[0] !== w[k-1]) begin
        nfail++;
        $error("FAIL t5_bit_direct: observed %0b at bit %0d", in_slice_b[0], k - 1);
      end
      step();
    end
    `CHK("t5_done", done_b, 1);
    `CHK("t5_res_out", res_out_b, 32'hDEAD_BEEF);

    // Full-width instance: one RUN cycle per op, chained back to back
    op_c = {32'h0, 32'hDEAD_BEEF};
    start_c = 1'b1;
    #1;
    `CHK("t6_accept", accept_c, 1);
    exp_c.push_back(32'hDEAD_BEEF);
    step();
    `CHK("t6_first_last", {first_c, last_c}, 2'b11);
    `CHK("t6_in_slice", in_slice_c[31:0], 32'hDEAD_BEEF);
    `CHK("t6_res_live", res_live_c, 32'hDEAD_BEEF);
    op_c = {32'h0, 32'h0123_4567};
    #1;
    `CHK("t6_chain_accept", accept_c, 1);
    exp_c.push_back(32'h0123_4567);
    step();
    start_c = 1'b0;
    `CHK("t6_done1", done_c, 1);
    `CHK("t6_res_out1", res_out_c, 32'hDEAD_BEEF);
    `CHK("t6_busy2", busy_c, 1);
    `CHK("t6_in_slice2", in_slice_c[31:0], 32'h0123_4567);
    step();
    `CHK("t6_done2", done_c, 1);
    `CHK("t6_res_out2", res_out_c, 32'h0123_4567);
    `CHK("t6_idle", busy_c, 0);

    // Every expected result must have been retired
    `CHK("sb_a_empty", exp_a.size(), 0);
    `CHK("sb_b_empty", exp_b.size(), 0);
    `CHK("sb_c_empty", exp_c.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/tinyqv_slice_seq.md
Name: tinyqv_slice_seq

Overview:
- Parametrised slice sequencer for the nibble-serial TinyQV datapath.
- Latches up to N_IN full-width operands on start, then presents them LSB-first one SLICE_W slice per cycle.
- Reassembles the core's result slices into a full word and provides a slice index, first/last strobes, stall support and back-to-back operation.
- Replaces ad-hoc free-running counter and slicing logic around the core; sits between the fetch/decode/memory side and the serial core.

Parameters:
- XLEN, 32, word width of operands and result.
- SLICE_W, 4, bits processed per cycle; legal values 1, 2, 4, 8, 16, 32; XLEN % SLICE_W == 0 (elaboration error otherwise).
- N_IN, 4, number of operand channels serialised (e.g. pc, next_pc, imm, data_in).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; operands sampled in the same cycle.
- stall  input  1  freeze sequencing for this cycle.
- op_in  input  N_IN*XLEN  operand channels; channel c at [c*XLEN +: XLEN].
- res_slice  input  SLICE_W  result slice from core for the current index.
- in_slice  output  N_IN*SLICE_W  current slice of each latched operand; channel c at [c*SLICE_W +: SLICE_W].
- slice_idx  output  clog2(XLEN/SLICE_W) (min 1)  current slice index.
- busy  output  1  operation in progress.
- first  output  1  busy && slice_idx==0.
- last  output  1  busy && slice_idx==NSLICE-1.
- accept  output  1  start taken this cycle.
- done  output  1  one-cycle pulse, res_out newly valid.
- res_out  output  XLEN  registered assembled result.
- res_live  output  XLEN  {res_slice, res_reg[XLEN-SLICE_W-1:0]}; equals the final result combinationally during an unstalled last cycle.

Behaviour:
- NSLICE = XLEN/SLICE_W. States: IDLE, RUN.
- Reset values: state IDLE, slice_idx 0, busy 0, first 0, last 0, done 0, accept 0, res_out 0, internal operand and result registers 0; in_slice 0.
- accept = start && !rst && (state==IDLE || (last && !stall)).
- On accept: op_reg <= op_in, slice_idx <= 0, state <= RUN. The first slice appears the cycle after accept, so latency from start to first is 1 cycle.
- RUN, stall=1: slice_idx, res_reg and op_reg hold. in_slice, first and last stay stable.
- RUN, stall=0: res_reg[slice_idx*SLICE_W +: SLICE_W] <= res_slice.
  - If not last: slice_idx++.
  - If last: res_out <= res_live, done <= 1 next cycle, and state <= IDLE unless accept (then RUN, index 0).
- Unstalled operation length is exactly NSLICE RUN cycles. done is asserted on the cycle after last.
- in_slice = op_reg[c][slice_idx*SLICE_W +: SLICE_W] while busy, otherwise 0.
- start while busy and not (last && !stall) is ignored. accept=0 and the operands are not latched.
- Back-to-back: with start held during the unstalled last cycle there is no idle bubble. The done pulse of operation N coincides with first of operation N+1.
- SLICE_W == XLEN: NSLICE=1, first and last assert together, and each operation takes 1 cycle.
- rst mid-operation:
  - Abort to reset values immediately at the clock edge.
  - No done pulse.
  - res_out is cleared.
- slice_idx wraps only via the last-to-0 transition; it never exceeds NSLICE-1.

Decomposition:
- Package tinyqv_slice_pkg holds:
  - state enum (IDLE, RUN);
  - localparam helper function nslice(XLEN, SLICE_W);
  - index-width function (clog2 with minimum 1).
- Single module; no sub-module needed. The operand mux may be a generate loop over N_IN.

Test Plan:
- Defaults; start with ch0=0x12345678, stall=0 → in_slice ch0 = 8,7,6,5,4,3,2,1 on the 8 cycles after accept; first on cycle 1; last on cycle 8; done on cycle 9; busy low on cycle 9.
- res_slice driven = slice_idx each cycle → res_out=0x76543210 with done; res_live=0x76543210 during last.
- Stall high for 2 cycles at slice_idx=3 → idx, in_slice and first/last held; done arrives at cycle 11; res_out still 0x76543210.
- start held through last with op_in ch1=0xA5A5A5A5 → accept on last; next cycle shows first=1 with done=1; ch1 slices 5,A,5,A,… follow. start asserted mid-run → accept=0 and the operation is unaffected.
- rst asserted at slice_idx=5 → next cycle busy=0, idx=0, res_out=0, in_slice=0; no done pulse; a following start proceeds normally.
- Instances SLICE_W=1 and SLICE_W=32 with res_slice looped from in_slice ch0, op=0xDEADBEEF → res_out=0xDEADBEEF after 32 and 1 RUN cycles respectively.
